// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite encodings plus the small helpers used by the BRAM slave.
//   Contents:
//     HTRANS_*      transfer type encodings
//     HSIZE_*       transfer size encodings (byte/half/word only)
//     HRESP_*       response encodings
//     err_state_e   states of the two-cycle ERROR response sequencer
//     byte_merge()  per-byte select between two 32-bit words
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // ERR1: first error cycle (stalls the bus), ERR2: second cycle (completes it)
    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

    // Byte i of the result comes from 'pri' when sel[i] is set, else from 'alt'
    function automatic logic [31:0] byte_merge(input logic [3:0]  sel,
                                               input logic [31:0] pri,
                                               input logic [31:0] alt);
        logic [31:0] r;
        r = alt;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? pri[8*i +: 8] : alt[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_bram_lane_decode.sv
// ---------------------------------------------------------------------------
// ahb_bram_lane_decode
//   Combinational lane decoder: turns HSIZE and the low address bits into a
//   4-bit byte-lane mask and flags transfers the RAM cannot serve.
//   Ports:
//     hsize      in  3  transfer size
//     addr_lo    in  2  HADDR[1:0]
//     mask       out 4  byte lanes touched by the transfer
//     bad_align  out 1  misaligned half/word, or unsupported size (>word)
// ---------------------------------------------------------------------------
module ahb_bram_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       bad_align
);

    // Size/offset to lane mask; sizes above word are reported as bad
    always_comb begin
        mask      = 4'b0000;
        bad_align = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                mask      = 4'b0001 << addr_lo;
                bad_align = 1'b0;
            end
            HSIZE_HALF: begin
                mask      = addr_lo[1] ? 4'b1100 : 4'b0011;
                bad_align = addr_lo[0];
            end
            HSIZE_WORD: begin
                mask      = 4'b1111;
                bad_align = (addr_lo != 2'b00);
            end
            default: begin
                mask      = 4'b0000;
                bad_align = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_bram_ctrl
//   AHB-Lite slave in front of a 2**ADDR_WIDTH x 32 block RAM with a
//   byte-masked write port (A) and a 1-cycle-latency read port (B).
//   Zero-wait OKAY transfers, read-after-write forwarding, two-cycle ERROR
//   response for misaligned/oversized accesses and protected writes.
//   Ports:
//     HCLK, HRESETn             clock, async active-low reset
//     HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY   AHB-Lite slave inputs
//     wp_en                     write-protect region below WP_LIMIT
//     HREADYOUT/HRESP/HRDATA    AHB-Lite slave outputs
//     bram_addra/dina/wea       RAM write port
//     bram_addrb/doutb          RAM read port
// ---------------------------------------------------------------------------
module ahb_bram_ctrl
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter logic [31:0] WP_LIMIT   = 32'h0000_4000
)
(
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    input  logic                  wp_en,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    err_state_e            state_r, state_s;
    logic                  hreadyout_r, hresp_r;
    logic [3:0]            wea_r;
    logic [ADDR_WIDTH-1:0] wr_idx_r;
    logic                  rd_valid_r;
    logic [3:0]            fwd_mask_r;
    logic [31:0]           fwd_data_r;

    logic [3:0]            mask_s;
    logic                  bad_align_s;
    logic                  active_s, accept_s, illegal_s;
    logic                  err_s, rd_addr_s, wr_addr_s, collide_s;
    logic [ADDR_WIDTH-1:0] idx_s;

    ahb_bram_lane_decode u_lane_decode (
        .hsize     (HSIZE),
        .addr_lo   (HADDR[1:0]),
        .mask      (mask_s),
        .bad_align (bad_align_s)
    );

    // Address-phase qualification; ERR1 never samples even if HREADY glitches high
    assign active_s  = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign accept_s  = HSEL & active_s & HREADY & (state_r != ST_ERR1);
    assign idx_s     = HADDR[ADDR_WIDTH+1:2];
    assign illegal_s = bad_align_s | (HWRITE & wp_en & (HADDR < WP_LIMIT));
    assign err_s     = accept_s &  illegal_s;
    assign rd_addr_s = accept_s & ~illegal_s & ~HWRITE;
    assign wr_addr_s = accept_s & ~illegal_s &  HWRITE;

    // RAM read port looks at the live address so data lands in the next cycle;
    // a read hitting the word being written this cycle sees stale RAM data
    assign collide_s  = rd_addr_s & (wea_r != 4'b0000) & (wr_idx_r == idx_s);
    assign bram_addrb = idx_s;
    assign bram_addra = wr_idx_r;
    assign bram_dina  = HWDATA;
    assign bram_wea   = wea_r;

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = rd_valid_r ? byte_merge(fwd_mask_r, fwd_data_r, bram_doutb)
                                  : 32'h0000_0000;

    // Error sequencer next state
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_OK:   state_s = err_s ? ST_ERR1 : ST_OK;
            ST_ERR1: state_s = ST_ERR2;
            ST_ERR2: state_s = err_s ? ST_ERR1 : ST_OK;
            default: state_s = ST_OK;
        endcase
    end

    // Error sequencer state and registered HREADYOUT/HRESP
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_OK;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_s;
            hreadyout_r <= (state_s != ST_ERR1);
            hresp_r     <= (state_s == ST_OK) ? HRESP_OKAY : HRESP_ERROR;
        end
    end

    // Phase registers: write lanes/index, read-pending flag, forwarding capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wea_r      <= 4'b0000;
            wr_idx_r   <= '0;
            rd_valid_r <= 1'b0;
            fwd_mask_r <= 4'b0000;
            fwd_data_r <= 32'h0000_0000;
        end else if (HREADY) begin
            wea_r      <= wr_addr_s ? mask_s : 4'b0000;
            wr_idx_r   <= wr_addr_s ? idx_s : wr_idx_r;
            rd_valid_r <= rd_addr_s;
            fwd_mask_r <= collide_s ? wea_r : 4'b0000;
            fwd_data_r <= collide_s ? HWDATA : fwd_data_r;
        end
    end

endmodule
